// File: rtl/lt24_touch_scanner.sv
// LT24 resistive-touch scanner: debounces pen-down, runs X-then-Y ADS7843 conversions
// over a bit-banged SPI, and exposes the samples to Nios II through Avalon-MM.
module lt24_touch_scanner #(
    parameter int unsigned DCLK_HALF  = 25,
    parameter int unsigned DEBOUNCE   = 1000,
    parameter int unsigned SAMPLE_GAP = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    input  logic        lt24_touch_penirq_n,
    input  logic        lt24_touch_dout,
    input  logic        lt24_touch_busy,
    output logic        lt24_touch_cs,
    output logic        lt24_touch_dclk,
    output logic        lt24_touch_din
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE - 1);
    localparam logic [31:0] HALF_LAST = 32'(DCLK_HALF - 1);
    localparam logic [31:0] GAP_LAST  = 32'(SAMPLE_GAP - 1);

    state_t      r_state, w_state_nxt;
    logic        r_pen_meta, r_pen_sync, r_dout_meta, r_dout_sync;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic        r_half, w_half_nxt;
    logic [4:0]  r_k, w_k_nxt;
    logic        r_axis, w_axis_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [11:0] r_shift, w_shift_nxt;
    logic [11:0] r_x, w_x_nxt;
    logic        w_frame_done, w_pen_set, w_pen_clr;
    logic        r_enable, r_irq_en, r_pen_down, r_valid;
    logic        w_valid_nxt, w_irq_en_nxt, w_frame_active;
    logic [11:0] r_data_x, r_data_y;
    logic [15:0] r_count;
    logic        r_cs, r_dclk, r_din, r_irq;
    logic [31:0] r_readdata, w_rd_mux;
    logic        w_unused;

    assign w_unused = ^{lt24_touch_busy, avs_writedata[31:2]};

    // Two-flop synchronizers for the asynchronous ADC inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pen_meta  <= 1'b1;
            r_pen_sync  <= 1'b1;
            r_dout_meta <= 1'b0;
            r_dout_sync <= 1'b0;
        end else begin
            r_pen_meta  <= lt24_touch_penirq_n;
            r_pen_sync  <= r_pen_meta;
            r_dout_meta <= lt24_touch_dout;
            r_dout_sync <= r_dout_meta;
        end
    end

    // FSM next-state and conversion datapath
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_half_nxt   = r_half;
        w_k_nxt      = r_k;
        w_axis_nxt   = r_axis;
        w_cmd_nxt    = r_cmd;
        w_shift_nxt  = r_shift;
        w_x_nxt      = r_x;
        w_frame_done = 1'b0;
        w_pen_set    = 1'b0;
        w_pen_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pen_sync || !r_enable) begin
                    w_cnt_nxt = 32'd0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = ST_START;
                    w_pen_set   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_START: begin
                w_state_nxt = ST_SHIFT;
                w_cmd_nxt   = 8'hD0;
                w_axis_nxt  = 1'b0;
                w_k_nxt     = 5'd1;
                w_half_nxt  = 1'b0;
                w_cnt_nxt   = 32'd0;
                w_shift_nxt = 12'd0;
            end
            ST_SHIFT: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = 32'd0;
                    if (!r_half) begin
                        // DCLK rises on this edge; capture result bits of periods 10..21
                        w_half_nxt = 1'b1;
                        if ((r_k >= 5'd10) && (r_k <= 5'd21)) begin
                            w_shift_nxt = {r_shift[10:0], r_dout_sync};
                        end else begin
                            w_shift_nxt = r_shift;
                        end
                    end else begin
                        w_half_nxt = 1'b0;
                        if (r_k == 5'd24) begin
                            if (!r_axis) begin
                                w_x_nxt    = r_shift;
                                w_cmd_nxt  = 8'h90;
                                w_axis_nxt = 1'b1;
                                w_k_nxt    = 5'd1;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_k_nxt = r_k + 5'd1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                w_state_nxt  = ST_GAP;
                w_cnt_nxt    = 32'd0;
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = 32'd0;
                    if (r_enable && !r_pen_sync) begin
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_pen_clr   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    // FSM state register, datapath registers and registered SPI pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
            r_half  <= 1'b0;
            r_k     <= 5'd0;
            r_axis  <= 1'b0;
            r_cmd   <= 8'd0;
            r_shift <= 12'd0;
            r_x     <= 12'd0;
            r_cs    <= 1'b1;
            r_dclk  <= 1'b0;
            r_din   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_k     <= w_k_nxt;
            r_axis  <= w_axis_nxt;
            r_cmd   <= w_cmd_nxt;
            r_shift <= w_shift_nxt;
            r_x     <= w_x_nxt;
            // Pins follow the next state so they line up with the state they describe
            r_cs    <= !((w_state_nxt == ST_START) || (w_state_nxt == ST_SHIFT));
            r_dclk  <= (w_state_nxt == ST_SHIFT) && w_half_nxt;
            r_din   <= ((w_state_nxt == ST_SHIFT) && !w_half_nxt && (w_k_nxt >= 5'd1) && (w_k_nxt <= 5'd8))
                       ? w_cmd_nxt[3'(5'd8 - w_k_nxt)] : 1'b0;
        end
    end

    assign w_frame_active = (r_state == ST_START) || (r_state == ST_SHIFT) || (r_state == ST_DONE);

    // A completing frame outranks a simultaneous DATA read when updating valid
    always_comb begin
        w_valid_nxt  = r_valid;
        w_irq_en_nxt = r_irq_en;
        w_rd_mux     = 32'd0;
        if (w_frame_done) begin
            w_valid_nxt = 1'b1;
        end else if (avs_read && (avs_address == 2'd2)) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
        if (avs_write && (avs_address == 2'd0)) begin
            w_irq_en_nxt = avs_writedata[1];
        end else begin
            w_irq_en_nxt = r_irq_en;
        end
        case (avs_address)
            2'd0:    w_rd_mux = {30'd0, r_irq_en, r_enable};
            2'd1:    w_rd_mux = {29'd0, w_frame_active, r_valid, r_pen_down};
            2'd2:    w_rd_mux = {4'd0, r_data_x, 4'd0, r_data_y};
            2'd3:    w_rd_mux = {16'd0, r_count};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Control/status registers, result latch, read port and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_pen_down <= 1'b0;
            r_valid    <= 1'b0;
            r_data_x   <= 12'd0;
            r_data_y   <= 12'd0;
            r_count    <= 16'd0;
            r_irq      <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            if (avs_write && (avs_address == 2'd0)) begin
                r_enable <= avs_writedata[0];
            end
            r_irq_en <= w_irq_en_nxt;
            if (w_pen_set) begin
                r_pen_down <= 1'b1;
            end else if (w_pen_clr) begin
                r_pen_down <= 1'b0;
            end
            if (w_frame_done) begin
                r_data_x <= r_x;
                r_data_y <= r_shift;
                r_count  <= r_count + 16'd1;
            end
            r_valid <= w_valid_nxt;
            r_irq   <= w_valid_nxt && w_irq_en_nxt;
            if (avs_read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign avs_readdata    = r_readdata;
    assign irq             = r_irq;
    assign lt24_touch_cs   = r_cs;
    assign lt24_touch_dclk = r_dclk;
    assign lt24_touch_din  = r_din;

endmodule

// File: tb/tb_lt24_touch_scanner.sv
// Directed self-checking bench for lt24_touch_scanner with a behavioural ADS7843 model.
module tb_lt24_touch_scanner;

    localparam int DH     = 3;
    localparam int DEB    = 20;
    localparam int GAP    = 40;
    localparam int CS_LOW = 1 + 96 * DH;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        irq;
    logic        pen_n;
    logic        dout = 1'b0;
    logic        busy;
    logic        cs, dclk, din;

    lt24_touch_scanner #(.DCLK_HALF(DH), .DEBOUNCE(DEB), .SAMPLE_GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
        .lt24_touch_penirq_n(pen_n), .lt24_touch_dout(dout), .lt24_touch_busy(busy),
        .lt24_touch_cs(cs), .lt24_touch_dclk(dclk), .lt24_touch_din(din)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ADC model: shifts out the 12-bit sample on falling DCLK, records the command bits
    logic [11:0] m_x = 12'd0, m_y = 12'd0;
    logic [7:0]  m_cmd_x = 8'd0, m_cmd_y = 8'd0;
    logic        m_prev_cs = 1'b1, m_prev_dclk = 1'b0, m_last_din = 1'b0, m_axis = 1'b0;
    int          m_k = 0;

    always @(posedge clk) begin
        logic [11:0] val;
        #1;
        if (cs == 1'b0 && m_prev_cs == 1'b1) begin
            m_k = 1;
            m_axis = 1'b0;
        end else if (cs == 1'b0 && dclk == 1'b0 && m_prev_dclk == 1'b1) begin
            m_k = m_k + 1;
            if (m_k > 24) begin
                m_k = 1;
                m_axis = 1'b1;
            end
        end
        if (cs == 1'b0 && dclk == 1'b1 && m_prev_dclk == 1'b0 && m_k <= 8) begin
            if (m_axis) m_cmd_y = {m_cmd_y[6:0], m_last_din};
            else        m_cmd_x = {m_cmd_x[6:0], m_last_din};
        end
        if (dclk == 1'b0) m_last_din = din;
        val = m_axis ? m_y : m_x;
        dout = (cs == 1'b0 && m_k >= 10 && m_k <= 21) ? val[21 - m_k] : 1'b0;
        m_prev_cs = cs;
        m_prev_dclk = dclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic wait_cs(input string name, input logic lvl, input int bound, output int n);
        n = 0;
        while (cs !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(cs), 32'(lvl));
    endtask

    task automatic count_cs_low(input int ncyc, output int lows);
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (cs == 1'b0) lows++;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        int lows;

        vecs[0] = '{1'b0, 2'd1, 32'd0, 32'h0000_0002, "status_valid"};
        vecs[1] = '{1'b0, 2'd2, 32'd0, 32'h0ABC_0123, "data_xy"};
        vecs[2] = '{1'b0, 2'd1, 32'd0, 32'h0000_0000, "status_cleared"};
        vecs[3] = '{1'b0, 2'd3, 32'd0, 32'h0000_0001, "count_one"};
        vecs[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'd0, "wr_status"};
        vecs[5] = '{1'b1, 2'd3, 32'h0000_1234, 32'd0, "wr_count"};
        vecs[6] = '{1'b0, 2'd1, 32'd0, 32'h0000_0000, "status_ro"};
        vecs[7] = '{1'b0, 2'd3, 32'd0, 32'h0000_0001, "count_ro"};
        vecs[8] = '{1'b0, 2'd0, 32'd0, 32'h0000_0003, "ctrl_rw"};

        reset_n = 1'b0;
        avs_address = 2'd0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = 32'd0;
        pen_n = 1'b1;
        busy = 1'b0;
        repeat (3) tick();
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_dclk", 32'(dclk), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Glitch one cycle short of the debounce window
        wr(2'd0, 32'h3);
        pen_n = 1'b0;
        repeat (DEB - 1) tick();
        pen_n = 1'b1;
        count_cs_low(60, lows);
        check("glitch_no_cs", 32'(lows), 32'd0);
        rd(2'd3, d);
        check("glitch_count", d, 32'd0);

        // Single frame, pen lifted mid-frame
        m_x = 12'hABC;
        m_y = 12'h123;
        pen_n = 1'b0;
        wait_cs("single_cs_fall", 1'b0, 200, n);
        rd(2'd1, d);
        check("single_status_active", d, 32'h5);
        pen_n = 1'b1;
        wait_cs("single_cs_rise", 1'b1, 1000, n);
        check("single_cs_low_len", 32'(n + 1), 32'(CS_LOW));
        check("single_cmd_x", 32'(m_cmd_x), 32'hD0);
        check("single_cmd_y", 32'(m_cmd_y), 32'h90);
        tick();
        check("single_irq", 32'(irq), 32'd1);
        count_cs_low(GAP + 10, lows);
        check("single_no_frame2", 32'(lows), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
                if (vecs[i].addr == 2'd2) check("irq_after_data_read", 32'(irq), 32'd0);
            end
        end

        // Asynchronous reset in the middle of a conversion
        pen_n = 1'b0;
        wait_cs("rst_cs_fall", 1'b0, 200, n);
        repeat (50) tick();
        rd(2'd1, d);
        check("rst_pre_status", d, 32'h5);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_cs", 32'(cs), 32'd1);
        check("midrst_dclk", 32'(dclk), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_readdata", avs_readdata, 32'd0);
        pen_n = 1'b1;
        tick();
        reset_n = 1'b1;
        rd(2'd1, d);
        check("midrst_status", d, 32'd0);
        rd(2'd3, d);
        check("midrst_count", d, 32'd0);
        rd(2'd0, d);
        check("midrst_ctrl", d, 32'd0);

        // Continuous pen: three frames, then lift during the fourth
        wr(2'd0, 32'h3);
        m_x = 12'h3C5;
        m_y = 12'hC3A;
        pen_n = 1'b0;
        wait_cs("cont_first_fall", 1'b0, 200, n);
        for (int f = 1; f <= 3; f++) begin
            wait_cs("cont_rise", 1'b1, 1000, n);
            check("cont_cs_low_len", 32'(n), 32'(CS_LOW));
            if (f < 3) begin
                wait_cs("cont_fall", 1'b0, 200, n);
                check("cont_cs_high_len", 32'(n), 32'(GAP + 1));
            end
        end
        tick();
        rd(2'd3, d);
        check("cont_count3", d, 32'd3);
        m_x = 12'h5A5;
        m_y = 12'hA5A;
        wait_cs("cont_f4_fall", 1'b0, 200, n);
        pen_n = 1'b1;
        wait_cs("cont_f4_rise", 1'b1, 1000, n);
        count_cs_low(GAP + 20, lows);
        check("cont_no_frame5", 32'(lows), 32'd0);
        rd(2'd1, d);
        check("cont_status_pen_up", d, 32'h2);
        rd(2'd2, d);
        check("cont_data_overwrite", d, 32'h05A5_0A5A);
        rd(2'd3, d);
        check("cont_count4", d, 32'd4);

        // DATA read landing on the DONE cycle
        m_x = 12'h001;
        m_y = 12'hFFF;
        pen_n = 1'b0;
        wait_cs("coinc_fall", 1'b0, 200, n);
        pen_n = 1'b1;
        wait_cs("coinc_rise", 1'b1, 1000, n);
        rd(2'd2, d);
        check("coinc_old_data", d, 32'h05A5_0A5A);
        rd(2'd1, d);
        check("coinc_status_valid", d, 32'h3);
        rd(2'd2, d);
        check("coinc_new_data", d, 32'h0001_0FFF);
        rd(2'd1, d);
        check("coinc_status_after", d, 32'h1);
        repeat (GAP + 10) tick();

        // Enable cleared mid-frame
        m_x = 12'h800;
        m_y = 12'h001;
        pen_n = 1'b0;
        wait_cs("en_fall", 1'b0, 200, n);
        repeat (20) tick();
        wr(2'd0, 32'h0);
        wait_cs("en_rise", 1'b1, 1000, n);
        check("en_cs_low_len", 32'(n + 21), 32'(CS_LOW));
        count_cs_low(GAP + 30, lows);
        check("en_no_next_frame", 32'(lows), 32'd0);
        check("en_irq_masked", 32'(irq), 32'd0);
        rd(2'd1, d);
        check("en_status_idle", d, 32'h2);
        rd(2'd3, d);
        check("en_count6", d, 32'd6);
        rd(2'd2, d);
        check("en_data", d, 32'h0800_0001);
        pen_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
